// File: rtl/csa_shift_add_ctrl_if.sv
// Operand, adder and product signals between csa_shift_add_ctrl and its neighbours.
// The master side drives operands, the adder sum and downstream ready.
interface csa_shift_add_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic [3:0] add_a;
  logic [3:0] add_b;
  logic [1:0] add_c;
  logic [4:0] add_sum;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_prod;

  modport master (
    output in_valid, in_a, in_b, add_sum, out_ready,
    input  in_ready, add_a, add_b, add_c, out_valid, out_prod
  );

  modport slave (
    input  in_valid, in_a, in_b, add_sum, out_ready,
    output in_ready, add_a, add_b, add_c, out_valid, out_prod
  );
endinterface

// File: rtl/csa_shift_add_ctrl.sv
// Sequential 4x4 shift-add multiplier controller driving an external carry-save adder.
// Optional CSA_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are zero.
module csa_shift_add_ctrl (
  input  logic                 clk,
  input  logic                 rst_n,
  csa_shift_add_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e     state_q, state_d;
  logic [3:0] mcand_q, mcand_d;
  logic [3:0] acc_q, acc_d;
  logic [3:0] q_q, q_d;
  logic [2:0] step_q, step_d;

`ifdef CSA_EARLY_EXIT_EN
  logic       rest_zero;
  logic [7:0] shifted;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      mcand_q <= 4'h0;
      acc_q   <= 4'h0;
      q_q     <= 4'h0;
      step_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    mcand_d       = mcand_q;
    acc_d         = acc_q;
    q_d           = q_q;
    step_d        = step_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.add_a     = 4'h0;
    bus.add_b     = 4'h0;
    bus.add_c     = 2'b00;
`ifdef CSA_EARLY_EXIT_EN
    // Bits q[3-step:0] are the multiplier bits not yet consumed.
    rest_zero = (q_q & (4'hF >> step_q[1:0])) == 4'h0;
    shifted   = {acc_q, q_q} >> (3'd4 - step_q);
`endif

    unique case (state_q)
      StIdle: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          mcand_d = bus.in_a;
          q_d     = bus.in_b;
          acc_d   = 4'h0;
          step_d  = 3'd0;
          state_d = StCalc;
        end
      end

      StCalc: begin
        bus.add_a = acc_q;
        step_d    = step_q + 3'd1;
`ifdef CSA_EARLY_EXIT_EN
        if (rest_zero) begin
          {acc_d, q_d} = shifted;
          state_d      = StDone;
        end else begin
          bus.add_b = q_q[0] ? mcand_q : 4'h0;
          acc_d     = bus.add_sum[4:1];
          q_d       = {bus.add_sum[0], q_q[3:1]};
          if (step_q == 3'd3) state_d = StDone;
        end
`else
        bus.add_b = q_q[0] ? mcand_q : 4'h0;
        // Sum LSB becomes a finished product bit shifted in at the top of q.
        acc_d     = bus.add_sum[4:1];
        q_d       = {bus.add_sum[0], q_q[3:1]};
        if (step_q == 3'd3) state_d = StDone;
`endif
      end

      StDone: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  assign bus.out_prod = {acc_q, q_q};

  // Product must stay put while downstream stalls.
  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    bus.out_valid && !bus.out_ready |=> bus.out_valid && $stable(bus.out_prod));

  a_no_accept_busy: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q != StIdle) |-> !bus.in_ready);

endmodule
